// File: rtl/mfda_valve_sequencer.sv
// Control-layer sequencer for MFDA chips: drives the control valve, peristaltic pump
// and flush pads from one command port. It also provides timed pump strokes and a timed flush.
module mfda_valve_sequencer #(
    parameter int unsigned N_CTRL       = 13,
    parameter int unsigned N_PUMP       = 2,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned FLUSH_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [N_CTRL-1:0]     cmd_mask,
    input  logic [N_PUMP-1:0]     cmd_pump_sel,
    input  logic [CNT_W-1:0]      cmd_period,
    input  logic [CNT_W-1:0]      cmd_strokes,
    input  logic                  abort,
    output logic [N_CTRL-1:0]     pad_ctrl,
    output logic [3*N_PUMP-1:0]   pad_pump,
    output logic [N_CTRL-1:0]     pad_flush_ctrl,
    output logic [3*N_PUMP-1:0]   pad_flush_pump,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      stroke_count
);

    localparam int unsigned      PUMP_W     = 3 * N_PUMP;
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PUMP,
        ST_FLUSH
    } state_t;

    typedef enum logic [1:0] {
        OP_SET_CTRL = 2'd0,
        OP_PUMP     = 2'd1,
        OP_FLUSH    = 2'd2,
        OP_RSVD     = 2'd3
    } op_t;

    state_t              state, state_nxt;
    logic [N_CTRL-1:0]   ctrl_hold, ctrl_hold_nxt;
    logic [CNT_W-1:0]    period_r, period_nxt;
    logic [CNT_W-1:0]    strokes_r, strokes_nxt;
    logic [N_PUMP-1:0]   sel_r, sel_nxt;
    logic [2:0]          phase, phase_nxt;
    logic [CNT_W-1:0]    phase_cnt, phase_cnt_nxt;
    logic [CNT_W-1:0]    flush_cnt, flush_cnt_nxt;

    logic                cmd_ready_nxt;
    logic [N_CTRL-1:0]   pad_ctrl_nxt;
    logic [PUMP_W-1:0]   pad_pump_nxt;
    logic [N_CTRL-1:0]   pad_flush_ctrl_nxt;
    logic [PUMP_W-1:0]   pad_flush_pump_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic [CNT_W-1:0]    stroke_count_nxt;

    logic [CNT_W-1:0]    phase_last;
    logic [CNT_W-1:0]    stroke_inc;
    logic                terminal;
    logic                finish;

    // Gray-like valve walk {v2,v1,v0}; adjacent phases differ by one valve.
    function automatic logic [2:0] phase_pattern(input logic [2:0] ph);
        logic [2:0] p;
        case (ph)
            3'd0:    p = 3'b011;
            3'd1:    p = 3'b001;
            3'd2:    p = 3'b101;
            3'd3:    p = 3'b100;
            3'd4:    p = 3'b110;
            3'd5:    p = 3'b010;
            default: p = 3'b111;
        endcase
        return p;
    endfunction

    function automatic logic [PUMP_W-1:0] pump_pads(input logic [2:0]        ph,
                                                   input logic [N_PUMP-1:0] sel);
        logic [PUMP_W-1:0] r;
        r = '1;
        for (int unsigned k = 0; k < N_PUMP; k++) begin
            if (sel[k]) r[3*k +: 3] = phase_pattern(ph);
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            ctrl_hold      <= '0;
            period_r       <= '0;
            strokes_r      <= '0;
            sel_r          <= '0;
            phase          <= '0;
            phase_cnt      <= '0;
            flush_cnt      <= '0;
            cmd_ready      <= 1'b1;
            pad_ctrl       <= '0;
            pad_pump       <= '1;
            pad_flush_ctrl <= '0;
            pad_flush_pump <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            stroke_count   <= '0;
        end else begin
            state          <= state_nxt;
            ctrl_hold      <= ctrl_hold_nxt;
            period_r       <= period_nxt;
            strokes_r      <= strokes_nxt;
            sel_r          <= sel_nxt;
            phase          <= phase_nxt;
            phase_cnt      <= phase_cnt_nxt;
            flush_cnt      <= flush_cnt_nxt;
            cmd_ready      <= cmd_ready_nxt;
            pad_ctrl       <= pad_ctrl_nxt;
            pad_pump       <= pad_pump_nxt;
            pad_flush_ctrl <= pad_flush_ctrl_nxt;
            pad_flush_pump <= pad_flush_pump_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            stroke_count   <= stroke_count_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        ctrl_hold_nxt      = ctrl_hold;
        period_nxt         = period_r;
        strokes_nxt        = strokes_r;
        sel_nxt            = sel_r;
        phase_nxt          = phase;
        phase_cnt_nxt      = phase_cnt;
        flush_cnt_nxt      = flush_cnt;
        pad_ctrl_nxt       = pad_ctrl;
        pad_pump_nxt       = pad_pump;
        pad_flush_ctrl_nxt = pad_flush_ctrl;
        pad_flush_pump_nxt = pad_flush_pump;
        busy_nxt           = busy;
        done_nxt           = 1'b0;
        stroke_count_nxt   = stroke_count;
        terminal           = 1'b0;
        finish             = 1'b0;
        phase_last         = (period_r > CNT_W'(1)) ? period_r - CNT_W'(1) : '0;
        stroke_inc         = (stroke_count == '1) ? stroke_count : stroke_count + CNT_W'(1);

        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    case (op_t'(cmd_op))
                        OP_SET_CTRL: begin
                            ctrl_hold_nxt = cmd_mask;
                            pad_ctrl_nxt  = cmd_mask;
                            done_nxt      = 1'b1;
                        end
                        OP_PUMP: begin
                            period_nxt       = cmd_period;
                            strokes_nxt      = cmd_strokes;
                            sel_nxt          = cmd_pump_sel;
                            stroke_count_nxt = '0;
                            phase_nxt        = '0;
                            phase_cnt_nxt    = '0;
                            pad_pump_nxt     = pump_pads(3'd0, cmd_pump_sel);
                            busy_nxt         = 1'b1;
                            state_nxt        = ST_PUMP;
                        end
                        OP_FLUSH: begin
                            flush_cnt_nxt      = '0;
                            pad_flush_ctrl_nxt = '1;
                            pad_flush_pump_nxt = '1;
                            pad_ctrl_nxt       = '0;
                            pad_pump_nxt       = '0;
                            busy_nxt           = 1'b1;
                            state_nxt          = ST_FLUSH;
                        end
                        default: done_nxt = 1'b1;
                    endcase
                end
            end

            ST_PUMP: begin
                // The stroke still counts when abort lands on the wrap edge, so a
                // same-cycle abort and terminal count report the full stroke.
                if (phase_cnt == phase_last) begin
                    phase_cnt_nxt = '0;
                    if (phase == 3'd5) begin
                        phase_nxt        = 3'd0;
                        stroke_count_nxt = stroke_inc;
                        terminal         = (strokes_r != '0) && (stroke_inc == strokes_r);
                    end else begin
                        phase_nxt = phase + 3'd1;
                    end
                end else begin
                    phase_cnt_nxt = phase_cnt + CNT_W'(1);
                end
                finish = abort || terminal;
                if (finish) begin
                    pad_pump_nxt = '1;
                    busy_nxt     = 1'b0;
                    done_nxt     = 1'b1;
                    state_nxt    = ST_IDLE;
                end else begin
                    pad_pump_nxt = pump_pads(phase_nxt, sel_r);
                end
            end

            ST_FLUSH: begin
                finish = abort || (flush_cnt == FLUSH_LAST);
                if (finish) begin
                    pad_flush_ctrl_nxt = '0;
                    pad_flush_pump_nxt = '0;
                    pad_ctrl_nxt       = ctrl_hold;
                    pad_pump_nxt       = '1;
                    busy_nxt           = 1'b0;
                    done_nxt           = 1'b1;
                    state_nxt          = ST_IDLE;
                end else begin
                    flush_cnt_nxt = flush_cnt + CNT_W'(1);
                end
            end

            default: state_nxt = ST_IDLE;
        endcase

        cmd_ready_nxt = (state_nxt == ST_IDLE);
    end

endmodule

// File: tb/tb_mfda_valve_sequencer.sv
// Scoreboard bench for mfda_valve_sequencer: stimulus queues timed pad expectations
// and done-pulse records, and a negedge monitor pops and compares them.
module tb_mfda_valve_sequencer;

    localparam int unsigned N_CTRL = 13;
    localparam int unsigned N_PUMP = 2;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned FLUSH  = 64;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [N_CTRL-1:0]   cmd_mask;
    logic [N_PUMP-1:0]   cmd_pump_sel;
    logic [CNT_W-1:0]    cmd_period;
    logic [CNT_W-1:0]    cmd_strokes;
    logic                abort;
    logic [N_CTRL-1:0]   pad_ctrl;
    logic [3*N_PUMP-1:0] pad_pump;
    logic [N_CTRL-1:0]   pad_flush_ctrl;
    logic [3*N_PUMP-1:0] pad_flush_pump;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    stroke_count;

    mfda_valve_sequencer #(
        .N_CTRL(N_CTRL), .N_PUMP(N_PUMP), .CNT_W(CNT_W), .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_pump_sel(cmd_pump_sel),
        .cmd_period(cmd_period), .cmd_strokes(cmd_strokes), .abort(abort),
        .pad_ctrl(pad_ctrl), .pad_pump(pad_pump), .pad_flush_ctrl(pad_flush_ctrl),
        .pad_flush_pump(pad_flush_pump), .busy(busy), .done(done),
        .stroke_count(stroke_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       nm;
    } texp_t;

    typedef struct {
        int          cyc;
        logic [31:0] sc;
        logic [31:0] pc;
        logic [31:0] pp;
    } dexp_t;

    localparam int S_CTRL = 0, S_PUMP = 1, S_FCTRL = 2, S_FPUMP = 3,
                   S_BUSY = 4, S_DONE = 5, S_STROKE = 6, S_READY = 7;

    texp_t tq[$];
    dexp_t dq[$];
    int    cyc   = 0;
    int    tests = 0;
    int    fails = 0;
    logic [2:0] pat [6];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic expt(int c, int s, logic [31:0] v, string nm);
        texp_t e;
        e.cyc = c; e.sig = s; e.val = v; e.nm = nm;
        tq.push_back(e);
    endtask

    task automatic expd(int c, logic [31:0] sc, logic [31:0] pc, logic [31:0] pp);
        dexp_t d;
        d.cyc = c; d.sc = sc; d.pc = pc; d.pp = pp;
        dq.push_back(d);
    endtask

    // Returns the cycle index of the accepting edge; outputs it produces are
    // visible at the following negedge under that same index.
    task automatic issue(input logic [1:0] op, input logic [N_CTRL-1:0] mask,
                         input logic [N_PUMP-1:0] sel, input logic [CNT_W-1:0] per,
                         input logic [CNT_W-1:0] strk, output int t);
        cmd_valid = 1'b1; cmd_op = op; cmd_mask = mask;
        cmd_pump_sel = sel; cmd_period = per; cmd_strokes = strk;
        @(posedge clk); #1;
        t = cyc;
        cmd_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [31:0] cur [8];
        dexp_t d;
        int i;
        cur[S_CTRL]   = 32'(pad_ctrl);
        cur[S_PUMP]   = 32'(pad_pump);
        cur[S_FCTRL]  = 32'(pad_flush_ctrl);
        cur[S_FPUMP]  = 32'(pad_flush_pump);
        cur[S_BUSY]   = 32'(busy);
        cur[S_DONE]   = 32'(done);
        cur[S_STROKE] = 32'(stroke_count);
        cur[S_READY]  = 32'(cmd_ready);
        i = 0;
        while (i < tq.size()) begin
            if (tq[i].cyc == cyc) begin
                check(tq[i].nm, cur[tq[i].sig], tq[i].val);
                tq.delete(i);
            end else if (tq[i].cyc < cyc) begin
                tests++; fails++;
                $display("FAIL %s: expectation for cycle %0d never sampled", tq[i].nm, tq[i].cyc);
                tq.delete(i);
            end else begin
                i++;
            end
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                d = dq.pop_front();
                check("done_cycle", 32'(cyc), 32'(d.cyc));
                check("done_stroke_count", 32'(stroke_count), d.sc);
                check("done_pad_ctrl", 32'(pad_ctrl), d.pc);
                check("done_pad_pump", 32'(pad_pump), d.pp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [5:0] pp;
        pat[0] = 3'b011; pat[1] = 3'b001; pat[2] = 3'b101;
        pat[3] = 3'b100; pat[4] = 3'b110; pat[5] = 3'b010;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_mask = '0;
        cmd_pump_sel = '0; cmd_period = '0; cmd_strokes = '0; abort = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        expt(cyc + 1, S_CTRL, 32'h0, "rst_pad_ctrl");
        expt(cyc + 1, S_PUMP, 32'h3F, "rst_pad_pump");
        expt(cyc + 1, S_FCTRL, 32'h0, "rst_flush_ctrl");
        expt(cyc + 1, S_FPUMP, 32'h0, "rst_flush_pump");
        expt(cyc + 1, S_BUSY, 32'h0, "rst_busy");
        expt(cyc + 1, S_DONE, 32'h0, "rst_done");
        expt(cyc + 1, S_STROKE, 32'h0, "rst_stroke_count");
        expt(cyc + 1, S_READY, 32'h1, "rst_cmd_ready");
        repeat (2) @(posedge clk); #1;

        // SET_CTRL
        issue(2'd0, 13'h1A5, '0, '0, '0, t);
        expd(t, 0, 32'h1A5, 32'h3F);
        expt(t, S_CTRL, 32'h1A5, "set_pad_ctrl");
        expt(t, S_READY, 32'h1, "set_ready");
        expt(t + 1, S_DONE, 32'h0, "set_done_one_cycle");
        expt(t + 1, S_READY, 32'h1, "set_ready_after");
        repeat (3) @(posedge clk); #1;

        // PUMP sel=01, period 3, strokes 2
        issue(2'd1, '0, 2'b01, 16'd3, 16'd2, t);
        for (int k = 0; k < 36; k++) begin
            pp = {3'b111, pat[(k / 3) % 6]};
            expt(t + k, S_PUMP, 32'(pp), "pump_walk");
            expt(t + k, S_STROKE, (k < 18) ? 32'd0 : 32'd1, "pump_stroke_progress");
            if (k % 6 == 0) expt(t + k, S_BUSY, 32'h1, "pump_busy");
        end
        expt(t + 5, S_READY, 32'h0, "pump_not_ready");
        expt(t + 10, S_CTRL, 32'h1A5, "pump_ctrl_held");
        expd(t + 36, 2, 32'h1A5, 32'h3F);
        expt(t + 36, S_BUSY, 32'h0, "pump_end_busy");
        expt(t + 36, S_READY, 32'h1, "pump_end_ready");
        expt(t + 37, S_PUMP, 32'h3F, "pump_end_idle");
        repeat (40) @(posedge clk); #1;

        // continuous run, period 0, both pumps, abort sampled 20 edges in
        issue(2'd1, '0, 2'b11, 16'd0, 16'd0, t);
        for (int k = 0; k < 20; k++) begin
            pp = {pat[k % 6], pat[k % 6]};
            expt(t + k, S_PUMP, 32'(pp), "cont_walk");
        end
        expt(t, S_STROKE, 32'd0, "cont_stroke_cleared");
        expd(t + 20, 3, 32'h1A5, 32'h3F);
        expt(t + 20, S_BUSY, 32'h0, "abort_busy");
        expt(t + 22, S_STROKE, 32'd3, "abort_stroke_kept");
        repeat (19) @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (4) @(posedge clk); #1;

        // FLUSH with ctrl preset, competing command held during flush
        issue(2'd0, 13'h0F0, '0, '0, '0, t);
        expd(t, 3, 32'h0F0, 32'h3F);
        @(posedge clk); #1;
        issue(2'd2, '0, '0, '0, '0, t);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_mask = 13'h155;
        for (int k = 0; k < 64; k++) begin
            expt(t + k, S_FCTRL, 32'h1FFF, "flush_ctrl_pads");
            expt(t + k, S_FPUMP, 32'h3F, "flush_pump_pads");
            expt(t + k, S_CTRL, 32'h0, "flush_pad_ctrl");
            expt(t + k, S_PUMP, 32'h0, "flush_pad_pump");
        end
        expt(t + 10, S_READY, 32'h0, "flush_not_ready");
        expt(t + 64, S_FCTRL, 32'h0, "flush_end_ctrl_pads");
        expt(t + 64, S_FPUMP, 32'h0, "flush_end_pump_pads");
        expt(t + 64, S_READY, 32'h1, "flush_end_ready");
        expd(t + 64, 3, 32'h0F0, 32'h3F);
        expd(t + 65, 3, 32'h155, 32'h3F);
        expt(t + 65, S_CTRL, 32'h155, "held_cmd_applied");
        repeat (65) @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk); #1;

        // terminal count and abort on the same edge
        issue(2'd1, '0, 2'b10, 16'd1, 16'd1, t);
        expt(t + 5, S_PUMP, 32'({pat[5], 3'b111}), "same_last_phase");
        expd(t + 6, 1, 32'h155, 32'h3F);
        expt(t + 6, S_BUSY, 32'h0, "same_busy");
        expt(t + 7, S_DONE, 32'h0, "same_single_done");
        expt(t + 8, S_STROKE, 32'd1, "same_stroke_kept");
        repeat (5) @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (3) @(posedge clk); #1;

        // abort in IDLE: no done, no change
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        expt(cyc + 1, S_CTRL, 32'h155, "idle_abort_ctrl");
        expt(cyc + 1, S_READY, 32'h1, "idle_abort_ready");
        repeat (3) @(posedge clk); #1;

        // asynchronous reset mid-PUMP
        issue(2'd1, '0, 2'b11, 16'd2, 16'd0, t);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset_pad_pump", 32'(pad_pump), 32'h3F);
        check("areset_pad_ctrl", 32'(pad_ctrl), 32'h0);
        check("areset_busy", 32'(busy), 32'h0);
        check("areset_stroke_count", 32'(stroke_count), 32'h0);
        check("areset_flush_ctrl", 32'(pad_flush_ctrl), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        expt(cyc + 1, S_READY, 32'h1, "post_reset_ready");
        expt(cyc + 1, S_PUMP, 32'h3F, "post_reset_pump");
        repeat (3) @(posedge clk); #1;

        if (dq.size() != 0) begin
            tests++; fails++;
            $display("FAIL missing_done: got %0d pulses outstanding expected 0", dq.size());
        end
        if (tq.size() != 0) begin
            tests++; fails++;
            $display("FAIL unchecked_expectations: got %0d pending expected 0", tq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mfda_valve_sequencer.md
Name: mfda_valve_sequencer

Overview:
- Parametrised control-layer sequencer for MFDA chips. Drives the control-valve, peristaltic-pump and flush pads of a routed design from a single command port.
- Generalises the fixed-count pad wrapper in three ways: parametrised valve and pump counts, timed peristaltic actuation, and a timed flush mode.
- Sits between the host command interface and the chip's ctrl/pump/flush pad buses.
- Pad bit value 1 = valve pressurised (closed).

Parameters:
N_CTRL, 13, number of discrete control valves
N_PUMP, 2, number of 3-valve peristaltic pumps
CNT_W, 16, width of period, stroke and flush counters
FLUSH_CYCLES, 64, clock cycles a flush is held (must be >= 1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_op  input  2  0 SET_CTRL, 1 PUMP, 2 FLUSH, 3 reserved (accepted, no effect other than done pulse)
cmd_mask  input  N_CTRL  valve pattern for SET_CTRL
cmd_pump_sel  input  N_PUMP  pumps driven by PUMP
cmd_period  input  CNT_W  cycles per pump phase (0 treated as 1)
cmd_strokes  input  CNT_W  strokes to run (0 = continuous until abort)
abort  input  1  level; terminates PUMP/FLUSH
pad_ctrl  output  N_CTRL  control valve pads
pad_pump  output  3*N_PUMP  pump valve pads, pump k at bits [3k+2:3k]
pad_flush_ctrl  output  N_CTRL  flush pads for control lines
pad_flush_pump  output  3*N_PUMP  flush pads for pump lines
busy  output  1  high in PUMP or FLUSH
done  output  1  one-cycle pulse on command completion or abort
stroke_count  output  CNT_W  completed strokes of the current/last PUMP

Behaviour:
- Reset (async assert, sync release):
  - pad_ctrl = 0, pad_pump = all 1, flush pads = 0.
  - busy = 0, done = 0, stroke_count = 0, state = IDLE.
- Reset mid-operation returns immediately to these values.
- States: IDLE, PUMP, FLUSH. cmd_ready = (state == IDLE), registered; no commands are queued.
- Abort in IDLE is ignored.
- SET_CTRL (accepted at edge T): pad_ctrl = cmd_mask from T+1; done pulse in cycle T+1; state stays IDLE.
- PUMP (accepted at edge T):
  - Latch period, strokes and sel; clear stroke_count and the phase counter.
  - Enter PUMP. From T+1, each selected pump outputs phase 0.
  - Phase sequence {v2,v1,v0}: 011, 001, 101, 100, 110, 010. Adjacent phases differ by one bit.
  - Each phase lasts max(period,1) cycles.
  - Wrap-around phase 5 -> 0 increments stroke_count (saturating at all-ones).
  - If strokes != 0 and stroke_count reaches strokes: all pumps return to 111, state goes to IDLE, done pulses in the same cycle the outputs change.
  - Unselected pumps hold 111 throughout.
  - pad_ctrl is unchanged during PUMP.
- FLUSH (accepted at edge T):
  - From T+1 for exactly FLUSH_CYCLES cycles: all flush pads = 1, pad_ctrl = 0, pad_pump = 0 (all open).
  - Then flush pads = 0, pad_ctrl is restored from the held ctrl register, pad_pump = all 1.
  - Return to IDLE with a done pulse in the first restored cycle.
- abort sampled high at edge E in PUMP or FLUSH:
  - From E+1, outputs take their IDLE values; pad_ctrl is restored.
  - done pulses at E+1 and state = IDLE.
  - stroke_count keeps its value.
- Terminal count and abort in the same cycle: this is a single completion with a single done pulse.
- The cycle after returning to IDLE has cmd_ready = 1. A new command may be accepted in the done cycle.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst_n = 0 asynchronously mid-PUMP -> pad_pump = 6'b111111, pad_ctrl = 0, busy = 0 with no clock edge.
- SET_CTRL: cmd_mask = 13'h1A5 -> pad_ctrl = 13'h1A5 one cycle after accept; done pulse for 1 cycle; cmd_ready stays 1.
- PUMP:
  - Setup: N_PUMP = 2, sel = 2'b01, period = 3, strokes = 2.
  - pad_pump[2:0] walks 011,001,101,100,110,010, each held 3 cycles, twice (36 cycles).
  - pad_pump[5:3] = 111 throughout; stroke_count reaches 2.
  - done pulses at cycle 37 after accept, with pad_pump = 111111 in that same cycle.
- period = 0, strokes = 0 continuous run:
  - Each phase is held 1 cycle.
  - abort asserted after 20 cycles -> outputs idle the next cycle; done pulses; stroke_count = 3.
- FLUSH with FLUSH_CYCLES = 64 and pad_ctrl preset to 13'h0F0:
  - Flush pads all 1 for exactly 64 cycles; pad_ctrl = 0 during flush.
  - Afterwards pad_ctrl = 13'h0F0 and done pulses.
  - cmd_valid held high during flush is not accepted until cmd_ready returns.
- Same-cycle completion: abort asserted in the same cycle as the final phase wrap of strokes = 1 -> exactly one done pulse; stroke_count = 1.
